// File: rtl/i2c_slave_regfile.sv
// I2C target with a byte-wide register file, auto-incrementing pointer and write strobe.
// Latency: 3 clk from a pad transition to the internal bus-event pulse; sda_oe follows one clk after that.
// Backpressure: none; the block never stretches SCL and follows the master's pace.
module i2c_slave_regfile #(
   parameter logic [6:0] SLAVE_ADDR = 7'h50,
   parameter int         DEPTH      = 16,
   parameter int         PTR_W      = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             scl_in,
   input  logic             sda_in,
   output logic             sda_oe,
   output logic             busy,
   output logic             wr_valid,
   output logic [PTR_W-1:0] wr_addr,
   output logic [7:0]       wr_data
);

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      PTR,
      PTR_ACK,
      WRITE,
      WR_ACK,
      READ,
      RD_ACK,
      WAIT_STOP
   } state_t;

   // Sync stages reset to 1 so an idle bus never produces a spurious edge.
   logic [2:0] scl_sync;
   logic [2:0] sda_sync;
   logic       scl_rise;
   logic       scl_fall;
   logic       start_det;
   logic       stop_det;
   logic       sda_bit;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         scl_sync  <= 3'b111;
         sda_sync  <= 3'b111;
         scl_rise  <= 1'b0;
         scl_fall  <= 1'b0;
         start_det <= 1'b0;
         stop_det  <= 1'b0;
         sda_bit   <= 1'b1;
      end else begin
         scl_sync  <= {scl_sync[1:0], scl_in};
         sda_sync  <= {sda_sync[1:0], sda_in};
         scl_rise  <= scl_sync[1] & ~scl_sync[2];
         scl_fall  <= ~scl_sync[1] & scl_sync[2];
         start_det <= scl_sync[1] & scl_sync[2] & ~sda_sync[1] & sda_sync[2];
         stop_det  <= scl_sync[1] & scl_sync[2] & sda_sync[1] & ~sda_sync[2];
         sda_bit   <= sda_sync[1];
      end
   end

   state_t           state, state_nx;
   logic [2:0]       bit_cnt, bit_cnt_nx;
   logic [7:0]       shreg, shreg_nx;
   logic [PTR_W-1:0] ptr, ptr_nx;
   logic             ack_pend, ack_pend_nx;
   logic             rw, rw_nx;
   logic             sda_oe_nx;
   logic             busy_nx;
   logic             wr_valid_nx;
   logic [PTR_W-1:0] wr_addr_nx;
   logic [7:0]       wr_data_nx;
   logic             reg_we;
   logic [7:0]       regs [DEPTH];

   logic [7:0]       byte_in;
   logic             last_bit;
   logic             ptr_ok;
   logic [PTR_W-1:0] ptr_inc;

   assign byte_in  = {shreg[6:0], sda_bit};
   assign last_bit = (bit_cnt == 3'd7);
   assign ptr_ok   = (32'(byte_in) < DEPTH);
   assign ptr_inc  = (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         shreg    <= '0;
         ptr      <= '0;
         ack_pend <= 1'b0;
         rw       <= 1'b0;
         sda_oe   <= 1'b0;
         busy     <= 1'b0;
         wr_valid <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
      end else begin
         state    <= state_nx;
         bit_cnt  <= bit_cnt_nx;
         shreg    <= shreg_nx;
         ptr      <= ptr_nx;
         ack_pend <= ack_pend_nx;
         rw       <= rw_nx;
         sda_oe   <= sda_oe_nx;
         busy     <= busy_nx;
         wr_valid <= wr_valid_nx;
         wr_addr  <= wr_addr_nx;
         wr_data  <= wr_data_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else if (reg_we) begin
         regs[ptr] <= byte_in;
      end
   end

   always_comb begin
      state_nx    = state;
      bit_cnt_nx  = bit_cnt;
      shreg_nx    = shreg;
      ptr_nx      = ptr;
      ack_pend_nx = ack_pend;
      rw_nx       = rw;
      sda_oe_nx   = sda_oe;
      busy_nx     = busy;
      wr_valid_nx = 1'b0;
      wr_addr_nx  = wr_addr;
      wr_data_nx  = wr_data;
      reg_we      = 1'b0;

      if (stop_det) begin
         state_nx    = IDLE;
         busy_nx     = 1'b0;
         sda_oe_nx   = 1'b0;
         ack_pend_nx = 1'b0;
      end else if (start_det) begin
         state_nx    = ADDR;
         bit_cnt_nx  = '0;
         busy_nx     = 1'b0;
         sda_oe_nx   = 1'b0;
         ack_pend_nx = 1'b0;
      end else begin
         case (state)
            ADDR: begin
               if (scl_rise) begin
                  shreg_nx   = byte_in;
                  bit_cnt_nx = bit_cnt + 1'b1;
                  if (last_bit) begin
                     if (byte_in[7:1] == SLAVE_ADDR) begin
                        state_nx = ADDR_ACK;
                        busy_nx  = 1'b1;
                        rw_nx    = byte_in[0];
                     end else begin
                        state_nx = WAIT_STOP;
                     end
                  end
               end
            end
            // First SCL fall starts driving the ACK, the second one ends the ACK bit.
            ADDR_ACK, PTR_ACK, WR_ACK: begin
               if (scl_fall) begin
                  if (!ack_pend) begin
                     sda_oe_nx   = 1'b1;
                     ack_pend_nx = 1'b1;
                  end else begin
                     ack_pend_nx = 1'b0;
                     sda_oe_nx   = 1'b0;
                     bit_cnt_nx  = '0;
                     if (state == ADDR_ACK && rw) begin
                        state_nx  = READ;
                        shreg_nx  = regs[ptr];
                        sda_oe_nx = ~regs[ptr][7];
                     end else if (state == ADDR_ACK) begin
                        state_nx = PTR;
                     end else begin
                        state_nx = WRITE;
                     end
                  end
               end
            end
            PTR: begin
               if (scl_rise) begin
                  shreg_nx   = byte_in;
                  bit_cnt_nx = bit_cnt + 1'b1;
                  if (last_bit) begin
                     if (ptr_ok) begin
                        ptr_nx   = byte_in[PTR_W-1:0];
                        state_nx = PTR_ACK;
                     end else begin
                        state_nx = WAIT_STOP;
                     end
                  end
               end
            end
            // Write and pointer increment happen together, so an aborted byte leaves both untouched.
            WRITE: begin
               if (scl_rise) begin
                  shreg_nx   = byte_in;
                  bit_cnt_nx = bit_cnt + 1'b1;
                  if (last_bit) begin
                     reg_we      = 1'b1;
                     wr_valid_nx = 1'b1;
                     wr_addr_nx  = ptr;
                     wr_data_nx  = byte_in;
                     ptr_nx      = ptr_inc;
                     state_nx    = WR_ACK;
                  end
               end
            end
            // The pointer advances once a byte has been fully shifted out, even if the master NACKs it.
            READ: begin
               if (scl_fall) begin
                  if (last_bit) begin
                     sda_oe_nx = 1'b0;
                     ptr_nx    = ptr_inc;
                     state_nx  = RD_ACK;
                  end else begin
                     shreg_nx   = {shreg[6:0], 1'b0};
                     sda_oe_nx  = ~shreg[6];
                     bit_cnt_nx = bit_cnt + 1'b1;
                  end
               end
            end
            RD_ACK: begin
               if (scl_rise && !ack_pend) begin
                  if (sda_bit) state_nx = WAIT_STOP;
                  else         ack_pend_nx = 1'b1;
               end else if (scl_fall && ack_pend) begin
                  ack_pend_nx = 1'b0;
                  bit_cnt_nx  = '0;
                  shreg_nx    = regs[ptr];
                  sda_oe_nx   = ~regs[ptr][7];
                  state_nx    = READ;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: a bit-banged master on a wired-AND SDA line.
// Each scenario task drives the bus and checks acks, read data, strobes and status inline.
module tb_i2c_slave_regfile;

   localparam int H = 10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_line;
   logic       sda_oe;
   logic       busy;
   logic       wr_valid;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;

   int n_tests = 0;
   int n_fail = 0;

   logic [11:0] wr_log[$];
   logic        oe_seen = 1'b0;
   int          wv_run = 0;
   logic        wv_wide = 1'b0;

   assign sda_line = sda_m & ~sda_oe;

   always #5 clk = ~clk;

   i2c_slave_regfile #(.SLAVE_ADDR(7'h50), .DEPTH(16)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .scl_in(scl),
      .sda_in(sda_line),
      .sda_oe(sda_oe),
      .busy(busy),
      .wr_valid(wr_valid),
      .wr_addr(wr_addr),
      .wr_data(wr_data)
   );

   always @(negedge clk) begin
      if (wr_valid) begin
         wr_log.push_back({wr_addr, wr_data});
         wv_run = wv_run + 1;
         if (wv_run > 1) wv_wide = 1'b1;
      end else begin
         wv_run = 0;
      end
      if (sda_oe) oe_seen = 1'b1;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bit_xfer(input logic b, output logic s);
      sda_m = b;
      wait_clk(H);
      scl = 1'b1;
      wait_clk(H / 2);
      s = sda_line;
      wait_clk(H - H / 2);
      scl = 1'b0;
      wait_clk(2);
   endtask

   task automatic bus_start();
      sda_m = 1'b1;
      wait_clk(H);
      scl = 1'b1;
      wait_clk(H);
      sda_m = 1'b0;
      wait_clk(H);
      scl = 1'b0;
      wait_clk(2);
   endtask

   task automatic bus_stop();
      sda_m = 1'b0;
      wait_clk(H);
      scl = 1'b1;
      wait_clk(H);
      sda_m = 1'b1;
      wait_clk(H);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
      bit_xfer(1'b1, ack);
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bit_xfer(1'b1, s);
         d[i] = s;
      end
      bit_xfer(mack, s);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      wait_clk(5);
      n_tests++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rst_sda_oe got=%b exp=0", sda_oe); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
      n_tests++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wr_valid got=%b exp=0", wr_valid); end
      n_tests++; if (wr_addr !== 4'd0) begin n_fail++; $display("FAIL rst_wr_addr got=%0d exp=0", wr_addr); end
      n_tests++; if (wr_data !== 8'h00) begin n_fail++; $display("FAIL rst_wr_data got=%h exp=00", wr_data); end
      rst_n = 1'b1;
      wait_clk(5);
      n_tests++; if (sda_oe !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL post_rst_idle got oe=%b busy=%b exp 0 0", sda_oe, busy); end
   endtask

   task automatic test_write_burst();
      logic [3:0] a;
      logic       b;
      wr_log.delete();
      wv_wide = 1'b0;
      bus_start();
      write_byte(8'hA0, a[3]);
      b = busy;
      write_byte(8'h03, a[2]);
      write_byte(8'h11, a[1]);
      write_byte(8'h22, a[0]);
      bus_stop();
      n_tests++; if (a !== 4'b0000) begin n_fail++; $display("FAIL wb_acks got=%b exp=0000", a); end
      n_tests++; if (b !== 1'b1) begin n_fail++; $display("FAIL wb_busy_after_match got=%b exp=1", b); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wb_busy_after_stop got=%b exp=0", busy); end
      n_tests++; if (wr_log.size() !== 2) begin n_fail++; $display("FAIL wb_strobe_count got=%0d exp=2", wr_log.size()); end
      if (wr_log.size() == 2) begin
         n_tests++; if (wr_log[0] !== {4'd3, 8'h11}) begin n_fail++; $display("FAIL wb_strobe0 got=%h exp=311", wr_log[0]); end
         n_tests++; if (wr_log[1] !== {4'd4, 8'h22}) begin n_fail++; $display("FAIL wb_strobe1 got=%h exp=422", wr_log[1]); end
      end
      n_tests++; if (wv_wide !== 1'b0) begin n_fail++; $display("FAIL wb_strobe_width got wide=%b exp=0", wv_wide); end
   endtask

   task automatic test_read_rs();
      logic [3:0] a;
      logic [7:0] d0, d1, d2;
      logic       b;
      wr_log.delete();
      bus_start();
      write_byte(8'hA0, a[3]);
      write_byte(8'h03, a[2]);
      bus_start();
      write_byte(8'hA1, a[1]);
      read_byte(1'b0, d0);
      b = busy;
      read_byte(1'b1, d1);
      bus_stop();
      n_tests++; if (a[3:1] !== 3'b000) begin n_fail++; $display("FAIL rd_acks got=%b exp=000", a[3:1]); end
      n_tests++; if (d0 !== 8'h11) begin n_fail++; $display("FAIL rd_byte0 got=%h exp=11", d0); end
      n_tests++; if (d1 !== 8'h22) begin n_fail++; $display("FAIL rd_byte1 got=%h exp=22", d1); end
      n_tests++; if (b !== 1'b1) begin n_fail++; $display("FAIL rd_busy got=%b exp=1", b); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rd_busy_after_stop got=%b exp=0", busy); end
      // Pointer now 5: a read with no pointer phase returns regs[5].
      bus_start();
      write_byte(8'hA1, a[0]);
      read_byte(1'b1, d2);
      bus_stop();
      n_tests++; if (a[0] !== 1'b0) begin n_fail++; $display("FAIL rd_cont_ack got=%b exp=0", a[0]); end
      n_tests++; if (d2 !== 8'h00) begin n_fail++; $display("FAIL rd_cont_ptr5 got=%h exp=00", d2); end
      n_tests++; if (wr_log.size() !== 0) begin n_fail++; $display("FAIL rd_no_strobe got=%0d exp=0", wr_log.size()); end
   endtask

   task automatic test_wrap();
      logic [3:0] a;
      logic [7:0] d0, d1;
      logic       x;
      wr_log.delete();
      bus_start();
      write_byte(8'hA0, a[3]);
      write_byte(8'h0F, a[2]);
      write_byte(8'hAA, a[1]);
      write_byte(8'hBB, a[0]);
      bus_stop();
      n_tests++; if (a !== 4'b0000) begin n_fail++; $display("FAIL wrap_acks got=%b exp=0000", a); end
      n_tests++; if (wr_log.size() !== 2) begin n_fail++; $display("FAIL wrap_strobe_count got=%0d exp=2", wr_log.size()); end
      if (wr_log.size() == 2) begin
         n_tests++; if (wr_log[0] !== {4'd15, 8'hAA}) begin n_fail++; $display("FAIL wrap_strobe0 got=%h exp=faa", wr_log[0]); end
         n_tests++; if (wr_log[1] !== {4'd0, 8'hBB}) begin n_fail++; $display("FAIL wrap_strobe1 got=%h exp=0bb", wr_log[1]); end
      end
      bus_start();
      write_byte(8'hA0, x);
      write_byte(8'h0F, x);
      bus_start();
      write_byte(8'hA1, x);
      read_byte(1'b0, d0);
      read_byte(1'b1, d1);
      bus_stop();
      n_tests++; if (d0 !== 8'hAA) begin n_fail++; $display("FAIL wrap_reg15 got=%h exp=aa", d0); end
      n_tests++; if (d1 !== 8'hBB) begin n_fail++; $display("FAIL wrap_reg0 got=%h exp=bb", d1); end
   endtask

   task automatic test_mismatch();
      logic [2:0] a;
      logic       b;
      wr_log.delete();
      oe_seen = 1'b0;
      bus_start();
      write_byte(8'hA2, a[2]);
      b = busy;
      write_byte(8'h05, a[1]);
      write_byte(8'h77, a[0]);
      bus_stop();
      n_tests++; if (a !== 3'b111) begin n_fail++; $display("FAIL mm_nack got=%b exp=111", a); end
      n_tests++; if (oe_seen !== 1'b0) begin n_fail++; $display("FAIL mm_sda_driven got=%b exp=0", oe_seen); end
      n_tests++; if (b !== 1'b0) begin n_fail++; $display("FAIL mm_busy got=%b exp=0", b); end
      n_tests++; if (wr_log.size() !== 0) begin n_fail++; $display("FAIL mm_no_strobe got=%0d exp=0", wr_log.size()); end
   endtask

   task automatic test_ptr_range();
      logic [2:0] a;
      wr_log.delete();
      bus_start();
      write_byte(8'hA0, a[2]);
      write_byte(8'h10, a[1]);
      write_byte(8'h55, a[0]);
      bus_stop();
      n_tests++; if (a !== 3'b011) begin n_fail++; $display("FAIL ptr_range_acks got=%b exp=011", a); end
      n_tests++; if (wr_log.size() !== 0) begin n_fail++; $display("FAIL ptr_range_no_strobe got=%0d exp=0", wr_log.size()); end
   endtask

   task automatic test_abort_sr();
      logic [7:0] d;
      logic       x;
      logic       ack;
      wr_log.delete();
      bus_start();
      write_byte(8'hA0, x);
      write_byte(8'h02, x);
      for (int i = 0; i < 4; i++) bit_xfer(1'b1, x);
      bus_start();
      write_byte(8'hA1, ack);
      read_byte(1'b1, d);
      bus_stop();
      n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL abort_addr_ack got=%b exp=0", ack); end
      n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL abort_reg2_ptr_kept got=%h exp=00", d); end
      n_tests++; if (wr_log.size() !== 0) begin n_fail++; $display("FAIL abort_no_strobe got=%0d exp=0", wr_log.size()); end
   endtask

   task automatic test_reset_mid_read();
      logic [7:0] d;
      logic       s;
      logic [2:0] a;
      bus_start();
      write_byte(8'hA0, a[2]);
      write_byte(8'h00, a[1]);
      bus_start();
      write_byte(8'hA1, a[0]);
      n_tests++; if (a !== 3'b000) begin n_fail++; $display("FAIL rmr_acks got=%b exp=000", a); end
      bit_xfer(1'b1, s);
      n_tests++; if (s !== 1'b1) begin n_fail++; $display("FAIL rmr_bit7 got=%b exp=1", s); end
      for (int i = 0; i < 2 * H && sda_oe !== 1'b1; i++) wait_clk(1);
      n_tests++; if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL rmr_driving_zero got=%b exp=1", sda_oe); end
      rst_n = 1'b0;
      wait_clk(1);
      rst_n = 1'b1;
      n_tests++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rmr_sda_oe got=%b exp=0", sda_oe); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmr_busy got=%b exp=0", busy); end
      sda_m = 1'b1;
      wait_clk(H);
      bus_stop();
      bus_start();
      write_byte(8'hA0, s);
      write_byte(8'h00, s);
      bus_start();
      write_byte(8'hA1, s);
      for (int i = 0; i < 5; i++) begin
         read_byte(i == 4, d);
         n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL rmr_cleared_reg%0d got=%h exp=00", i, d); end
      end
      bus_stop();
      bus_start();
      write_byte(8'hA0, s);
      write_byte(8'h0F, s);
      bus_start();
      write_byte(8'hA1, s);
      read_byte(1'b1, d);
      bus_stop();
      n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL rmr_cleared_reg15 got=%h exp=00", d); end
   endtask

   initial begin
      test_reset();
      test_write_burst();
      test_read_rs();
      test_wrap();
      test_mismatch();
      test_ptr_range();
      test_abort_sr();
      test_reset_mid_read();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
